// File: rtl/ycr_wbb_arb_pkg.sv
// rtl/ycr_wbb_arb_pkg.sv - state type and one-hot rotate/priority pick for ycr_wbb_arb
package ycr_wbb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  localparam int unsigned MAX_N = 8;

  // First set bit of req searching ptr, ptr+1, ... wrapping at n; ptr must be < n.
  function automatic logic [MAX_N-1:0] onehot_rr_pick(
    input logic [MAX_N-1:0] req,
    input logic [2:0]       ptr,
    input int unsigned      n
  );
    logic [MAX_N-1:0] gnt;
    logic             found;
    int unsigned      idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !found && req[idx[2:0]]) begin
        gnt[idx[2:0]] = 1'b1;
        found         = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/ycr_wbb_arb_if.sv
// rtl/ycr_wbb_arb_if.sv - requester and bridge-side Wishbone burst signals of ycr_wbb_arb
interface ycr_wbb_arb_if #(
  parameter int N  = 3,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int BW = 4,
  parameter int BL = 10
);
  logic [N-1:0]    wbm_stb_i;
  logic [N-1:0]    wbm_cyc_i;
  logic [N-1:0]    wbm_we_i;
  logic [N*AW-1:0] wbm_adr_i;
  logic [N*DW-1:0] wbm_dat_i;
  logic [N*BW-1:0] wbm_sel_i;
  logic [N*BL-1:0] wbm_bl_i;
  logic [DW-1:0]   wbm_dat_o;
  logic [N-1:0]    wbm_ack_o;
  logic [N-1:0]    wbm_lack_o;
  logic [N-1:0]    wbm_err_o;

  logic            wbs_cyc_o;
  logic            wbs_stb_o;
  logic [AW-1:0]   wbs_adr_o;
  logic            wbs_we_o;
  logic [DW-1:0]   wbs_dat_o;
  logic [BW-1:0]   wbs_sel_o;
  logic [BL-1:0]   wbs_bl_o;
  logic [DW-1:0]   wbs_dat_i;
  logic            wbs_ack_i;
  logic            wbs_lack_i;
  logic            wbs_err_i;

  logic [N-1:0]    arb_gnt_o;
  logic            arb_blerr_o;

  // Arbiter side: slave to the requesters, driving the bridge.
  modport slave (
    input  wbm_stb_i, wbm_cyc_i, wbm_we_i, wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_bl_i,
    output wbm_dat_o, wbm_ack_o, wbm_lack_o, wbm_err_o,
    output wbs_cyc_o, wbs_stb_o, wbs_adr_o, wbs_we_o, wbs_dat_o, wbs_sel_o, wbs_bl_o,
    input  wbs_dat_i, wbs_ack_i, wbs_lack_i, wbs_err_i,
    output arb_gnt_o, arb_blerr_o
  );

  modport master (
    output wbm_stb_i, wbm_cyc_i, wbm_we_i, wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_bl_i,
    input  wbm_dat_o, wbm_ack_o, wbm_lack_o, wbm_err_o,
    input  wbs_cyc_o, wbs_stb_o, wbs_adr_o, wbs_we_o, wbs_dat_o, wbs_sel_o, wbs_bl_o,
    output wbs_dat_i, wbs_ack_i, wbs_lack_i, wbs_err_i,
    input  arb_gnt_o, arb_blerr_o
  );
endinterface

// File: rtl/ycr_rr_arb.sv
// rtl/ycr_rr_arb.sv - N-input one-hot picker starting its search at ptr
module ycr_rr_arb
  import ycr_wbb_arb_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [N-1:0] gnt
);
  logic [MAX_N-1:0] req_w;
  logic [MAX_N-1:0] gnt_w;
  logic             unused_pick;

  assign req_w       = MAX_N'(req);
  assign gnt_w       = onehot_rr_pick(req_w, ptr, N);
  assign gnt         = gnt_w[N-1:0];
  assign unused_pick = ^gnt_w;
endmodule

// File: rtl/ycr_wbb_arb.sv
// rtl/ycr_wbb_arb.sv - burst arbiter of N requesters onto one Wishbone bridge port
// Define YCR_WBB_ARB_RR_EN for round-robin; otherwise fixed priority, lowest index wins.
module ycr_wbb_arb
  import ycr_wbb_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int BW = 4,
  parameter int BL = 10
) (
  input logic           wbm_clk_i,
  input logic           wbm_rst_n,
  ycr_wbb_arb_if.slave  bus
);
  arb_state_e    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d, pick;
  logic [BL-1:0] cnt_q, cnt_d;
  logic          blerr_q, blerr_d;
  logic [2:0]    ptr_q;
  logic          busy, release_w, len_bad;
  logic [BL:0]   bl_need, beats;

  ycr_rr_arb #(.N(N)) u_pick (
    .req (bus.wbm_stb_i & bus.wbm_cyc_i),
    .ptr (ptr_q),
    .gnt (pick)
  );

  assign busy      = (state_q == ST_BUSY);
  assign release_w = busy & (bus.wbs_lack_i | bus.wbs_err_i);

  // bl of zero stands for a full 2^BL-beat burst.
  assign bl_need = (bus.wbs_bl_o == '0) ? {1'b1, {BL{1'b0}}} : {1'b0, bus.wbs_bl_o};
  assign beats   = {1'b0, cnt_q} + (BL+1)'(1);
  assign len_bad = (beats != bl_need);

  always_comb begin
    bus.wbs_adr_o = '0;
    bus.wbs_we_o  = 1'b0;
    bus.wbs_dat_o = '0;
    bus.wbs_sel_o = '0;
    bus.wbs_bl_o  = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_q[i]) begin
        bus.wbs_adr_o = bus.wbs_adr_o | bus.wbm_adr_i[i*AW +: AW];
        bus.wbs_we_o  = bus.wbs_we_o  | bus.wbm_we_i[i];
        bus.wbs_dat_o = bus.wbs_dat_o | bus.wbm_dat_i[i*DW +: DW];
        bus.wbs_sel_o = bus.wbs_sel_o | bus.wbm_sel_i[i*BW +: BW];
        bus.wbs_bl_o  = bus.wbs_bl_o  | bus.wbm_bl_i[i*BL +: BL];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    blerr_d = 1'b0;
    unique case (state_q)
      ST_BUSY: begin
        if (bus.wbs_ack_i) cnt_d = cnt_q + BL'(1);
        if (release_w) begin
          state_d = ST_GAP;
          gnt_d   = '0;
          // Writes are acked locally by the bridge, so only reads are length-checked.
          blerr_d = bus.wbs_lack_i & ~bus.wbs_we_o & len_bad;
        end
      end
      default: begin
        if (|pick) begin
          state_d = ST_BUSY;
          gnt_d   = pick;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge wbm_clk_i) begin
    if (!wbm_rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      blerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      blerr_q <= blerr_d;
    end
  end

`ifdef YCR_WBB_ARB_RR_EN
  logic [2:0] gnt_idx, ptr_d;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_q[i]) gnt_idx = 3'(i);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (release_w) ptr_d = (gnt_idx == 3'(N-1)) ? 3'd0 : gnt_idx + 3'd1;
  end

  always_ff @(posedge wbm_clk_i) begin
    if (!wbm_rst_n) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end
`else
  assign ptr_q = '0;
`endif

  assign bus.wbs_stb_o   = busy;
  assign bus.wbs_cyc_o   = busy;
  assign bus.wbm_dat_o   = bus.wbs_dat_i;
  assign bus.wbm_ack_o   = gnt_q & {N{busy & bus.wbs_ack_i}};
  assign bus.wbm_lack_o  = gnt_q & {N{busy & bus.wbs_lack_i}};
  assign bus.wbm_err_o   = gnt_q & {N{busy & bus.wbs_err_i}};
  assign bus.arb_gnt_o   = gnt_q;
  assign bus.arb_blerr_o = blerr_q;
endmodule
